button_conditioner: RTL and testbench

//   Turns NUM_BTN raw, bouncy, asynchronous push-button inputs into clean signals.
//   Per button: 2-flop synchroniser, debouncer, rising-edge pulse.

---
 rtl/led_pkg.sv | 18 +
 rtl/btn_channel.sv | 100 ++++++++++
 rtl/button_conditioner.sv | 36 +++
 tb/tb_button_conditioner.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/led_pkg.sv
// Shared constants for the LED board button front end.
// Clock rate, default debounce/repeat timings and button indices.
package led_pkg;

   localparam int CLK_FREQ_HZ       = 50_000_000;
   localparam int DEBOUNCE_DEF      = CLK_FREQ_HZ / 100;
   localparam int REPEAT_DELAY_DEF  = CLK_FREQ_HZ / 2;
   localparam int REPEAT_PERIOD_DEF = CLK_FREQ_HZ / 5;

   localparam int BTN_NEXT   = 0;
   localparam int BTN_MODE   = 1;
   localparam int BTN_CYCLIC = 2;

   function automatic int cnt_w(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/btn_channel.sv
// One button: 2-flop sync, debounce, press pulse, optional auto-repeat.
// Auto-repeat logic exists only when BTN_AUTOREPEAT_EN is defined.
module btn_channel
   import led_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES      = DEBOUNCE_DEF,
   parameter int REPEAT_DELAY_CYCLES  = REPEAT_DELAY_DEF,
   parameter int REPEAT_PERIOD_CYCLES = REPEAT_PERIOD_DEF,
   parameter bit REPEAT_EN            = 1'b0
)(
   input  logic clk,
   input  logic async_nreset,
   input  logic btn_raw,
   output logic btn_level,
   output logic btn_re
);

   localparam int CW = cnt_w(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_CYCLES - 1);

   logic          r_s1;
   logic          r_s2;
   logic          r_level;
   logic          r_re;
   logic [CW-1:0] r_cnt;
   logic          w_diff;
   logic          w_done;
   logic          w_rise;
   logic          w_fall;
   logic          w_rep;

   assign w_diff = r_s2 ^ r_level;
   assign w_done = w_diff && (r_cnt == CMAX);
   assign w_rise = w_done && r_s2;
   assign w_fall = w_done && !r_s2;

   always_ff @(posedge clk or negedge async_nreset) begin
      if (!async_nreset) begin
         r_s1 <= 1'b0;
         r_s2 <= 1'b0;
      end else begin
         r_s1 <= btn_raw;
         r_s2 <= r_s1;
      end
   end

   // Any sample agreeing with the current level restarts the count.
   always_ff @(posedge clk or negedge async_nreset) begin
      if (!async_nreset) begin
         r_cnt   <= '0;
         r_level <= 1'b0;
      end else if (!w_diff) begin
         r_cnt <= '0;
      end else if (w_rise || w_fall) begin
         r_cnt   <= '0;
         r_level <= w_rise;
      end else begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge async_nreset) begin
      if (!async_nreset) r_re <= 1'b0;
      else               r_re <= w_rise | w_rep;
   end

`ifdef BTN_AUTOREPEAT_EN
   generate
      if (REPEAT_EN) begin : g_rep
         localparam int RW = cnt_w(REPEAT_DELAY_CYCLES);
         localparam logic [RW-1:0] RMAX =
            RW'(REPEAT_DELAY_CYCLES - 1);
         localparam logic [RW-1:0] RLOAD =
            RW'(REPEAT_DELAY_CYCLES - REPEAT_PERIOD_CYCLES);

         logic [RW-1:0] r_rcnt;
         logic          w_hit;

         assign w_hit = r_level && (r_rcnt == RMAX);
         assign w_rep = w_hit && !w_fall;

         // Reload keeps later pulses one period apart.
         always_ff @(posedge clk or negedge async_nreset) begin
            if (!async_nreset)          r_rcnt <= '0;
            else if (!r_level || w_fall) r_rcnt <= '0;
            else if (w_hit)             r_rcnt <= RLOAD;
            else                        r_rcnt <= r_rcnt + 1'b1;
         end
      end else begin : g_norep
         assign w_rep = 1'b0;
      end
   endgenerate
`else
   assign w_rep = 1'b0;
`endif

   assign btn_level = r_level;
   assign btn_re    = r_re;

endmodule

// File: rtl/button_conditioner.sv
// Conditions NUM_BTN raw push-buttons into debounced levels and press pulses.
// Optional auto-repeat per REPEAT_MASK when BTN_AUTOREPEAT_EN is defined.
module button_conditioner
   import led_pkg::*;
#(
   parameter int NUM_BTN              = 3,
   parameter int DEBOUNCE_CYCLES      = DEBOUNCE_DEF,
   parameter int REPEAT_DELAY_CYCLES  = REPEAT_DELAY_DEF,
   parameter int REPEAT_PERIOD_CYCLES = REPEAT_PERIOD_DEF,
   parameter logic [NUM_BTN-1:0] REPEAT_MASK = NUM_BTN'(1)
)(
   input  logic               clk,
   input  logic               async_nreset,
   input  logic [NUM_BTN-1:0] btn_raw,
   output logic [NUM_BTN-1:0] btn_level,
   output logic [NUM_BTN-1:0] btn_re
);

   generate
      for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
         btn_channel #(
            .DEBOUNCE_CYCLES      (DEBOUNCE_CYCLES),
            .REPEAT_DELAY_CYCLES  (REPEAT_DELAY_CYCLES),
            .REPEAT_PERIOD_CYCLES (REPEAT_PERIOD_CYCLES),
            .REPEAT_EN            (REPEAT_MASK[i])
         ) u_ch (
            .clk          (clk),
            .async_nreset (async_nreset),
            .btn_raw      (btn_raw[i]),
            .btn_level    (btn_level[i]),
            .btn_re       (btn_re[i])
         );
      end
   endgenerate

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner (debounce 8, repeat 20/6).
// Repeat expectations follow BTN_AUTOREPEAT_EN as compiled.
module tb_button_conditioner;

   localparam int NB = 3;
   localparam int DB = 8;
   localparam int RD = 20;
   localparam int RP = 6;
`ifdef BTN_AUTOREPEAT_EN
   localparam bit AR = 1'b1;
`else
   localparam bit AR = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          async_nreset;
   logic [NB-1:0] btn_raw;
   logic [NB-1:0] btn_level;
   logic [NB-1:0] btn_re;

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   button_conditioner #(
      .NUM_BTN              (NB),
      .DEBOUNCE_CYCLES      (DB),
      .REPEAT_DELAY_CYCLES  (RD),
      .REPEAT_PERIOD_CYCLES (RP),
      .REPEAT_MASK          (3'b001)
   ) dut (
      .clk          (clk),
      .async_nreset (async_nreset),
      .btn_raw      (btn_raw),
      .btn_level    (btn_level),
      .btn_re       (btn_re)
   );

   task automatic check(input string tag,
                        input logic [NB-1:0] obs,
                        input logic [NB-1:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_out(input string tag,
                          input logic [NB-1:0] lv,
                          input logic [NB-1:0] re);
      check({tag, "/lvl"}, btn_level, lv);
      check({tag, "/re"}, btn_re, re);
   endtask

   task automatic hold(input string tag, input int n,
                       input logic [NB-1:0] lv,
                       input logic [NB-1:0] re);
      for (int i = 0; i < n; i++) begin
         tick();
         chk_out(tag, lv, re);
      end
   endtask

   initial begin
      logic [NB-1:0] exp_re;
      async_nreset = 1'b1;
      btn_raw      = '0;
      #1 async_nreset = 1'b0;
      #11;
      chk_out("rst", 3'b000, 3'b000);
      tick();
      tick();
      @(negedge clk);
      async_nreset = 1'b1;
      hold("idle", 50, 3'b000, 3'b000);

      // press on 0: pulse on the 10th edge after the input change
      btn_raw = 3'b001;
      hold("p0_wait", DB + 1, 3'b000, 3'b000);
      tick();
      chk_out("p0_edge", 3'b001, 3'b001);
      hold("p0_after", 1, 3'b001, 3'b000);

      btn_raw = 3'b000;
      hold("r0_wait", DB + 1, 3'b001, 3'b000);
      tick();
      chk_out("r0_edge", 3'b000, 3'b000);

      btn_raw = 3'b100;
      hold("glitch_hi", 7, 3'b000, 3'b000);
      btn_raw = 3'b000;
      hold("glitch_lo", 20, 3'b000, 3'b000);

      for (int b = 0; b < 2; b++) begin
         btn_raw = 3'b010;
         hold("bounce_hi", 3, 3'b000, 3'b000);
         btn_raw = 3'b000;
         hold("bounce_lo", 3, 3'b000, 3'b000);
      end
      btn_raw = 3'b010;
      hold("p1_wait", DB + 1, 3'b000, 3'b000);
      tick();
      chk_out("p1_edge", 3'b010, 3'b010);
      hold("p1_hold", 30, 3'b010, 3'b000);
      btn_raw = 3'b000;
      hold("r1_wait", DB + 1, 3'b010, 3'b000);
      tick();
      chk_out("r1_edge", 3'b000, 3'b000);

      btn_raw = 3'b101;
      hold("p02_wait", DB + 1, 3'b000, 3'b000);
      tick();
      chk_out("p02_edge", 3'b101, 3'b101);

      for (int off = 1; off <= 60; off++) begin
         tick();
         exp_re = '0;
         exp_re[0] = AR && off >= RD && ((off - RD) % RP) == 0;
         chk_out($sformatf("rep_%0d", off), 3'b101, exp_re);
      end

      // reset lands mid-cycle, away from any clock edge
      #3 async_nreset = 1'b0;
      #1;
      chk_out("mid_rst", 3'b000, 3'b000);
      hold("in_rst", 2, 3'b000, 3'b000);
      @(negedge clk);
      async_nreset = 1'b1;
      hold("rel_wait", DB + 1, 3'b000, 3'b000);
      tick();
      chk_out("rel_edge", 3'b101, 3'b101);
      hold("rel_after", 1, 3'b101, 3'b000);

      btn_raw = 3'b000;
      hold("end_wait", DB + 1, 3'b101, 3'b000);
      tick();
      chk_out("end_edge", 3'b000, 3'b000);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
